// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// ALU/mux select codes and the bundle of decoded control strobes.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_RWB     = 4'd7,
        S_BRANCH  = 4'd8,
        S_JUMP    = 4'd9,
        S_IMMEX   = 4'd10,
        S_IMMWB   = 4'd11,
        S_ILLEGAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    // Also the encoding understood by the ALU control decoder.
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_AND   = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REG     = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SL2 = 2'b11
    } alu_src_b_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_source_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        pc_source_t pc_source;
        logic       trap;
    } ctrl_t;

    // Fetch-cycle controls; the IR and PC only load once memory delivers.
    function automatic ctrl_t fetch_ctrl(input logic mem_ready);
        ctrl_t c;
        c           = '0;
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PC_ALU;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_retire_counter.sv
// Free-running count of retired instructions, wrapping modulo 2^CNT_W.
module retire_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples its inputs before any of them change on this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control unit of a multicycle MIPS-subset datapath: registered FSM state,
// combinational decoded strobes, and a retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_write_cond_ne,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             trap,
    output logic [CNT_W-1:0] retired
);

    state_t     state_q;
    state_t     state_d;
    logic [5:0] opc_q;
    ctrl_t      ctrl;
    logic       retire;

    // The opcode is captured in DECODE; the IR may change afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opc_q <= opcode;
            end
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default before the case, so no
        // path through the decode can leave one unassigned and infer a latch.
        ctrl    = '0;
        state_d = state_q;
        retire  = 1'b0;

        case (state_q)
            S_FETCH: begin
                ctrl = fetch_ctrl(mem_ready);
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SL2;
                ctrl.alu_op    = ALU_ADD;
                case (opcode)
                    OP_RTYPE:       state_d = S_EXEC;
                    OP_LW, OP_SW:   state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI, OP_ANDI: state_d = S_IMMEX;
                    default:        state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                state_d        = (opc_q == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                retire          = 1'b1;
                state_d         = S_FETCH;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
                state_d        = S_RWB;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a        = 1'b1;
                ctrl.alu_src_b        = SRCB_REG;
                ctrl.alu_op           = ALU_SUB;
                ctrl.pc_source        = PC_ALUOUT;
                ctrl.pc_write_cond    = (opc_q == OP_BEQ);
                ctrl.pc_write_cond_ne = (opc_q == OP_BNE);
                retire                = 1'b1;
                state_d               = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PC_JUMP;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_IMMEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (opc_q == OP_ANDI) ? ALU_AND : ALU_ADD;
                state_d        = S_IMMWB;
            end
            S_IMMWB: begin
                ctrl.reg_write = 1'b1;
                retire         = 1'b1;
                state_d        = S_FETCH;
            end
            S_ILLEGAL: begin
                ctrl.trap = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A reset cycle looks like an idle fetch: no loads, no retire.
        if (rst) begin
            ctrl   = fetch_ctrl(1'b0);
            retire = 1'b0;
        end
    end

    assign pc_write         = ctrl.pc_write;
    assign pc_write_cond    = ctrl.pc_write_cond;
    assign pc_write_cond_ne = ctrl.pc_write_cond_ne;
    assign i_or_d           = ctrl.i_or_d;
    assign mem_read         = ctrl.mem_read;
    assign mem_write        = ctrl.mem_write;
    assign ir_write         = ctrl.ir_write;
    assign mem_to_reg       = ctrl.mem_to_reg;
    assign reg_dst          = ctrl.reg_dst;
    assign reg_write        = ctrl.reg_write;
    assign alu_src_a        = ctrl.alu_src_a;
    assign alu_src_b        = ctrl.alu_src_b;
    assign alu_op           = ctrl.alu_op;
    assign pc_source        = ctrl.pc_source;
    assign trap             = ctrl.trap;
    assign instr_done       = retire;
    assign state            = rst ? S_FETCH : state_q;

    retire_counter #(
        .CNT_W(CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .rst   (rst),
        .en    (retire),
        .count (retired)
    );

endmodule
